// File: rtl/puf_seq.sv
// Sequencer that walks one puf_bit through N_BITS derived challenges and
// assembles the captured responses into a word, aborting a bit on timeout.
module puf_seq #(
  parameter int N_BITS     = 8,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        chall_base,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [N_BITS-1:0] resp_word,
  output logic [7:0]        puf_chall,
  output logic              puf_rst,
  output logic              puf_en,
  input  logic              puf_resp,
  input  logic              puf_finish
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [IW-1:0] LAST_INDEX = IW'(N_BITS - 1);
  localparam logic [CW-1:0] LAST_CLR   = CW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] LAST_RUN   = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [IW-1:0] index;
  logic [CW-1:0] clr_cnt;
  logic [TW-1:0] timer;

  // Every output is a flop; puf_rst/puf_en are updated together with the
  // state transition so they always reflect the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      resp_word <= '0;
      puf_chall <= 8'h00;
      puf_rst   <= 1'b1;
      puf_en    <= 1'b0;
      index     <= '0;
      clr_cnt   <= '0;
      timer     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            puf_chall <= chall_base;
            index     <= '0;
            resp_word <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            clr_cnt   <= '0;
            state     <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          if (clr_cnt == LAST_CLR) begin
            timer   <= '0;
            puf_rst <= 1'b0;
            puf_en  <= 1'b1;
            state   <= S_RUN;
          end else begin
            clr_cnt <= clr_cnt + CW'(1);
          end
        end

        S_RUN: begin
          timer <= timer + TW'(1);
          // A finish on the final allowed cycle still counts as a capture.
          if (puf_finish) begin
            resp_word[index] <= puf_resp;
            puf_rst          <= 1'b1;
            puf_en           <= 1'b0;
            if (index == LAST_INDEX) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              index     <= index + IW'(1);
              puf_chall <= puf_chall + 8'h11;
              clr_cnt   <= '0;
              state     <= S_CLEAR;
            end
          end else if (timer == LAST_RUN) begin
            err     <= 1'b1;
            done    <= 1'b1;
            puf_rst <= 1'b1;
            puf_en  <= 1'b0;
            state   <= S_DONE;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_seq.sv
// Directed and randomized runs of puf_seq against a behavioural puf_bit
// stand-in and a reference computed directly from the challenge rules.
module tb_puf_seq;

  localparam int N   = 8;
  localparam int CLR = 2;
  localparam int TO  = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   chall_base = 8'h00;
  logic         busy, done, err;
  logic [N-1:0] resp_word;
  logic [7:0]   puf_chall;
  logic         puf_rst, puf_en, puf_resp, puf_finish;

  puf_seq #(.N_BITS(N), .CLR_CYCLES(CLR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chall_base(chall_base),
    .busy(busy), .done(done), .err(err), .resp_word(resp_word),
    .puf_chall(puf_chall), .puf_rst(puf_rst), .puf_en(puf_en),
    .puf_resp(puf_resp), .puf_finish(puf_finish)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // puf_bit stand-in: bit i finishes on RUN cycle delay_tab[i] (0 = never)
  int         delay_tab [16];
  logic [7:0] resp_mask = 8'hFF;
  logic       resp_inv = 1'b0;
  int         run_cnt = 0;
  int         bit_idx = 0;
  int         stable_bad = 0;
  logic [7:0] last_chall = 8'h00;
  logic [7:0] seen_chall [$];

  assign puf_finish = puf_en && !puf_rst && (delay_tab[bit_idx] != 0) &&
                      (run_cnt == delay_tab[bit_idx] - 1);
  assign puf_resp = (^(puf_chall & resp_mask)) ^ resp_inv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= 0;
      run_cnt <= 0;
      seen_chall.delete();
    end else begin
      if (start && !busy) begin
        bit_idx <= 0;
        seen_chall.delete();
      end
      if (puf_rst) run_cnt <= 0;
      else if (puf_en) run_cnt <= run_cnt + 1;
      if (puf_en && puf_finish) begin
        bit_idx <= bit_idx + 1;
        seen_chall.push_back(puf_chall);
      end
      if (puf_en) begin
        if (run_cnt > 0 && puf_chall !== last_chall) stable_bad <= stable_bad + 1;
        last_chall <= puf_chall;
      end
    end
  end

  // Reference results for one run
  logic [N-1:0] exp_word;
  logic         exp_err;
  int           exp_lat;
  int           exp_n;
  logic [7:0]   exp_chall [N];

  function automatic void refModel(input logic [7:0] base);
    logic [7:0] c;
    exp_err  = 1'b0;
    exp_word = '0;
    exp_lat  = 1;
    exp_n    = 0;
    for (int i = 0; i < N; i++) begin
      c = base + 8'(i * 17);
      if (delay_tab[i] == 0 || delay_tab[i] > TO) begin
        exp_lat += CLR + TO;
        exp_err = 1'b1;
        break;
      end
      exp_lat += CLR + delay_tab[i];
      exp_word[i] = (($countones(c & resp_mask) % 2) == 1) ^ resp_inv;
      exp_chall[exp_n] = c;
      exp_n++;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Starts a run, optionally pulses start on cycle 'inject' and/or during
  // the DONE cycle, and returns the start-edge-to-done latency in cycles.
  task automatic applyStimulus(input logic [7:0] base, input int inject,
                               input bit start_in_done, output int lat);
    @(negedge clk);
    chall_base = base;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    checkOutput("accept_busy", 32'(busy), 32'd1);
    checkOutput("accept_err_clr", 32'(err), 32'd0);
    checkOutput("accept_word_clr", 32'(resp_word), 32'd0);
    checkOutput("accept_chall", 32'(puf_chall), 32'(base));
    while (!done && lat < 1000) begin
      if (lat == inject) begin
        start = 1'b1;
        chall_base = ~base;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = start_in_done;
  endtask

  task automatic runAndCheck(input logic [7:0] base, input int inject,
                             input bit start_in_done);
    int lat;
    logic [N-1:0] word_at_done;
    refModel(base);
    applyStimulus(base, inject, start_in_done, lat);
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("busy_at_done", 32'(busy), 32'd1);
    checkOutput("err", 32'(err), 32'(exp_err));
    checkOutput("resp_word", 32'(resp_word), 32'(exp_word));
    checkOutput("chall_count", 32'(seen_chall.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < seen_chall.size(); i++)
      checkOutput($sformatf("chall[%0d]", i), 32'(seen_chall[i]), 32'(exp_chall[i]));
    checkOutput("chall_stable", 32'(stable_bad), 32'd0);
    word_at_done = resp_word;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("word_hold", 32'(resp_word), 32'(word_at_done));
    checkOutput("err_hold", 32'(err), 32'(exp_err));
    checkOutput("idle_puf_rst", 32'(puf_rst), 32'd1);
    checkOutput("idle_puf_en", 32'(puf_en), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) delay_tab[i] = 5;

    // Reset asserted mid-cycle must take effect without a clock edge
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_word", 32'(resp_word), 32'd0);
    checkOutput("rst_chall", 32'(puf_chall), 32'd0);
    checkOutput("rst_puf_rst", 32'(puf_rst), 32'd1);
    checkOutput("rst_puf_en", 32'(puf_en), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("idle_no_start", 32'(busy), 32'd0);

    // Nominal parity runs and nibble wrap
    runAndCheck(8'h00, 0, 1'b0);
    runAndCheck(8'h01, 0, 1'b0);
    runAndCheck(8'hF0, 0, 1'b0);

    // Dead oscillator on bit 3; start pulsed in the DONE cycle is ignored
    resp_mask = 8'h00;
    resp_inv  = 1'b1;
    delay_tab[3] = 0;
    runAndCheck(8'h3C, 0, 1'b1);

    // Finish on the last allowed cycle, with a stray start during RUN
    resp_mask = 8'hA5;
    resp_inv  = 1'b0;
    for (int i = 0; i < 16; i++) delay_tab[i] = TO;
    runAndCheck(8'h5A, 10, 1'b0);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      resp_mask = 8'($urandom);
      resp_inv  = 1'($urandom);
      for (int i = 0; i < 16; i++) begin
        delay_tab[i] = $urandom_range(1, TO + 2);
        if (delay_tab[i] > TO) delay_tab[i] = 0;
      end
      runAndCheck(8'($urandom), (r % 2 == 0) ? int'($urandom_range(2, 30)) : 0, 1'($urandom));
    end

    // Reset while bit 4 is being evaluated discards the partial word
    resp_mask = 8'hFF;
    resp_inv  = 1'b1;
    for (int i = 0; i < 16; i++) delay_tab[i] = 5;
    @(negedge clk);
    chall_base = 8'h77;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!(bit_idx == 4 && puf_en) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("reach_bit4", 32'(n < 500), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_word", 32'(resp_word), 32'd0);
    checkOutput("midrst_chall", 32'(puf_chall), 32'd0);
    checkOutput("midrst_puf_rst", 32'(puf_rst), 32'd1);
    checkOutput("midrst_puf_en", 32'(puf_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runAndCheck(8'h77, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
